// File: rtl/serial_adder_ctrl.sv
// Bit-serial word adder controller driving one external full-adder cell.
// Operands shift out LSB first; the sum word is rebuilt and reported with done.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             run;
  logic [WIDTH-1:0] s_nxt;

  assign run   = (state == RUN);
  assign s_nxt = {fa_sum, s_sh[WIDTH-1:1]};

  // The cell only sees live bits while stepping; quiet otherwise.
  assign fa_a   = run & a_sh[0];
  assign fa_b   = run & b_sh[0];
  assign fa_cin = run & carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            s_sh  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          s_sh  <= s_nxt;
          carry <= fa_cout;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= s_nxt;
            cout  <= fa_cout;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition controller that shares one one-bit full-adder cell across a WIDTH-bit add. It latches two operands and a carry-in on a start request. It then steps the external full-adder cell one bit per clock, LSB first, feeding each carry-out back as the next carry-in. It reassembles the sum word and reports completion with a one-cycle done pulse. It sits between a requester issuing word adds and the single full-adder cell, and is the only driver of that cell's inputs.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- cin  input  1  word carry-in; sampled on the accepting edge only.
- busy  output  1  high in RUN and DONE; low in IDLE.
- done  output  1  one-cycle completion pulse, high in DONE.
- sum  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  registered word carry-out; holds until the next completion.
- fa_a  output  1  to full-adder cell input A.
- fa_b  output  1  to full-adder cell input B.
- fa_cin  output  1  to full-adder cell carry-in.
- fa_sum  input  1  from full-adder cell sum; combinational path from fa_*.
- fa_cout  input  1  from full-adder cell carry-out; combinational path from fa_*.

## Operation
- Internal registers:
  - a_sh and b_sh: WIDTH-bit right-shift registers.
  - s_sh: WIDTH-bit shift register.
  - carry: 1 bit.
  - cnt: clog2(WIDTH) bits.
  - state: IDLE, RUN or DONE.
- IDLE:
  - fa_a, fa_b and fa_cin are driven 0.
  - If start=1: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, s_sh<=0, then go to RUN.
  - If start=0: stay in IDLE.
- RUN:
  - fa_a=a_sh[0], fa_b=b_sh[0] and fa_cin=carry. These are combinational decodes of registers, with no other logic in the path.
  - Each edge: s_sh<={fa_sum, s_sh[WIDTH-1:1]}, carry<=fa_cout, a_sh>>=1, b_sh>>=1, cnt<=cnt+1.
  - When cnt==WIDTH-1 on an edge:
    - Go to DONE.
    - sum<={fa_sum, s_sh[WIDTH-1:1]}, i.e. the final shifted value.
    - cout<=fa_cout.
- DONE:
  - done=1 and busy=1; fa_* are driven 0.
  - Unconditionally go to IDLE on the next edge.
  - start is ignored in this state.
- start in RUN or DONE is ignored. There is no queuing, and the in-flight operands are unaffected.
- Arithmetic: {cout,sum} = a + b + cin, taken modulo 2^(WIDTH+1). This is exact, with no overflow flag.
- cnt never wraps within an operation and is reloaded to 0 on acceptance.
- Reset values:
  - state=IDLE.
  - busy=0, done=0.
  - sum=0, cout=0.
  - fa_a=0, fa_b=0, fa_cin=0.
  - a_sh, b_sh, s_sh, carry and cnt are all 0.
- Reset mid-operation: rst=1 on any edge overrides all other activity and aborts the add. Consequences:
  - No done pulse is issued.
  - sum and cout return to 0.
  - The next start is accepted on the first edge with rst=0 in IDLE.

## Timing
- Accepting edge E0 is the first edge with state=IDLE, start=1 and rst=0.
- RUN occupies the cycles between E0 and E_WIDTH.
- Bit i is presented on fa_* in the cycle after edge E_i, for i = 0..WIDTH-1.
- DONE, the done pulse and valid sum/cout appear in the cycle after E_WIDTH. Latency from start to done is WIDTH cycles.
- The earliest next accept is E_(WIDTH+2): the edge leaving DONE lands in IDLE, and start is sampled on the following edge.
- Throughput is one add per WIDTH+2 cycles.
- busy rises in the cycle after E0 and falls in the cycle after E_(WIDTH+1).
- start held high continuously produces back-to-back adds at that rate.

## Test plan
- WIDTH=8, a=0x3C, b=0x5A, cin=0, start pulsed one cycle:
  - done asserted exactly 8 cycles after the accepting edge, for one cycle.
  - sum=0x96, cout=0.
- Carry ripple and wrap, run as two separate adds:
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; fa_cin sequence is 0,1,1,1,1,1,1,1.
  - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- start pulsed at cycles 3 and 6 during RUN of a=0x10, b=0x20 (the ignored pulses carry a=0xAA, b=0x55):
  - sum=0x30, cout=0.
  - Exactly one done pulse.
- rst asserted at cycle 4 of RUN:
  - Next cycle: busy=0, done=0, sum=0x00, cout=0, fa_*=0.
  - No done pulse follows.
  - A fresh start with a=0x01, b=0x01 yields sum=0x02.
- start held high continuously with a=0x80, b=0x80, cin=0:
  - done pulses every 10 cycles.
  - Each result is sum=0x00, cout=1.
  - busy is low for exactly one cycle between operations.
- Randomized/exhaustive check with WIDTH=4 and a scoreboard:
  - All 512 combinations of a, b, cin.
  - {cout,sum} equals a+b+cin for every combination.
  - fa_* are 0 whenever state is not RUN.
